m92_rom_fetch: RTL and testbench

- Downstream consumer of the M92 CPU address decoder.
- Takes the decoded `cpu_rom_memrq` / `rom_addr` for each V33 bus cycle and serves 16-bit program-ROM reads out of SDRAM.
- Keeps a one-line, 64-bit read cache so sequential opcode fetches avoid SDRAM round trips.
- Drives a ready/wait line back to the CPU bus logic; talks to the SDRAM controller over a toggle req/ack channel.

---
 rtl/m92_pkg.sv | 25 ++
 rtl/m92_rom_line_cache.sv | 40 ++++
 rtl/m92_rom_fetch.sv | 102 ++++++++++
 tb/tb_m92_rom_fetch.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/m92_pkg.sv
`default_nettype none
// ============================================================================
// Module      : m92_pkg
// Description : Shared types and constants for the M92 program-ROM fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
package m92_pkg;

    localparam int ROM_LINE_BYTES = 8;
    localparam int ROM_OFS_BITS   = $clog2(ROM_LINE_BYTES);

    typedef struct packed {
        logic [16:0] tag;
        logic [63:0] data;
        logic        valid;
    } rom_line_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/m92_rom_line_cache.sv
`default_nettype none
// ============================================================================
// Module      : m92_rom_line_cache
// Description : Single 64-bit ROM line with tag compare and 16-bit word select.
// Revision    : 1.0 - initial release
// ============================================================================
module m92_rom_line_cache
    import m92_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [16:0] i_tag,
    input  logic [1:0]  i_word_sel,
    input  logic        i_load,
    input  logic [63:0] i_load_data,
    input  logic        i_load_valid,
    input  logic        i_invalidate,
    output logic        o_hit,
    output logic [15:0] o_word
);

    rom_line_t r_line;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_line <= '0;
        end else if (i_load) begin
            r_line.tag   <= i_tag;
            r_line.data  <= i_load_data;
            r_line.valid <= i_load_valid;
        end else if (i_invalidate) begin
            r_line.valid <= 1'b0;
        end
    end

    assign o_hit  = r_line.valid && (r_line.tag == i_tag);
    assign o_word = r_line.data[{i_word_sel, 4'b0000} +: 16];

endmodule
`default_nettype wire

// File: rtl/m92_rom_fetch.sv
`default_nettype none
// ============================================================================
// Module      : m92_rom_fetch
// Description : Serves V33 program-ROM reads from SDRAM through a one-line cache.
// Revision    : 1.0 - initial release
// ============================================================================
module m92_rom_fetch
    import m92_pkg::*;
#(
    parameter int                SDR_AW   = 25,
    parameter logic [SDR_AW-1:0] ROM_BASE = '0
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              cpu_rom_memrq,
    input  logic [19:0]       rom_addr,
    input  logic              cpu_rd,
    input  logic              invalidate,
    output logic [15:0]       cpu_dout,
    output logic              cpu_ready,
    output logic [SDR_AW-1:0] sdr_addr,
    output logic              sdr_req,
    input  logic              sdr_ack,
    input  logic [63:0]       sdr_data
);

    fetch_state_t      r_state;
    logic [19:1]       r_addr;
    logic              r_inv_seen;
    logic [19:1]       w_addr;
    logic [SDR_AW-1:0] w_line_addr;
    logic              w_hit;
    logic [15:0]       w_word;
    logic              w_fill;
    logic              w_unused_bit0;

    // In IDLE the live bus address is compared so a hit can answer next cycle.
    assign w_addr        = (r_state == IDLE) ? rom_addr[19:1] : r_addr;
    assign w_line_addr   = ROM_BASE + SDR_AW'({w_addr[19:ROM_OFS_BITS], {ROM_OFS_BITS{1'b0}}});
    assign w_fill        = (r_state == WAIT) && (sdr_ack == sdr_req);
    assign w_unused_bit0 = rom_addr[0];

    m92_rom_line_cache u_line (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .i_tag        (w_addr[19:3]),
        .i_word_sel   (w_addr[2:1]),
        .i_load       (w_fill),
        .i_load_data  (sdr_data),
        .i_load_valid (!(r_inv_seen || invalidate)),
        .i_invalidate (invalidate),
        .o_hit        (w_hit),
        .o_word       (w_word)
    );

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_inv_seen <= 1'b0;
            cpu_dout   <= '0;
            cpu_ready  <= 1'b0;
            sdr_addr   <= '0;
            sdr_req    <= sdr_ack;
        end else begin
            cpu_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cpu_rd && cpu_rom_memrq) begin
                        r_addr <= rom_addr[19:1];
                        if (w_hit && !invalidate) begin
                            cpu_dout  <= w_word;
                            cpu_ready <= 1'b1;
                        end else begin
                            sdr_addr   <= w_line_addr;
                            sdr_req    <= ~sdr_req;
                            r_inv_seen <= 1'b0;
                            r_state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // An invalidate during the fill lets the data through but keeps the line unusable.
                    if (invalidate) begin
                        r_inv_seen <= 1'b1;
                    end
                    if (sdr_ack == sdr_req) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    cpu_dout  <= w_word;
                    cpu_ready <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m92_rom_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_m92_rom_fetch
// Description : Directed and randomized self-checking bench for m92_rom_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_m92_rom_fetch;

    localparam logic [24:0] ROM_BASE = 25'h100000;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        cpu_rom_memrq;
    logic [19:0] rom_addr;
    logic        cpu_rd;
    logic        invalidate;
    logic [15:0] cpu_dout;
    logic        cpu_ready;
    logic [24:0] sdr_addr;
    logic        sdr_req;
    logic        sdr_ack;
    logic [63:0] sdr_data;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: what the cached line should hold
    logic        m_valid;
    logic [16:0] m_tag;
    logic [63:0] m_data;

    m92_rom_fetch #(.SDR_AW(25), .ROM_BASE(ROM_BASE)) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .cpu_rom_memrq (cpu_rom_memrq),
        .rom_addr      (rom_addr),
        .cpu_rd        (cpu_rd),
        .invalidate    (invalidate),
        .cpu_dout      (cpu_dout),
        .cpu_ready     (cpu_ready),
        .sdr_addr      (sdr_addr),
        .sdr_req       (sdr_req),
        .sdr_ack       (sdr_ack),
        .sdr_data      (sdr_data)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [63:0] line, input logic [19:0] addr);
        case (addr[2:1])
            2'd0:    return line[15:0];
            2'd1:    return line[31:16];
            2'd2:    return line[47:32];
            default: return line[63:48];
        endcase
    endfunction

    // One CPU read; ack arrives lat cycles after the request, invalidate optionally
    // pulsed at wait cycle inv_cycle (== lat means on the ack cycle) or with the start.
    task automatic do_read(input logic [19:0] addr, input logic [63:0] line, input int lat,
                           input int inv_cycle, input bit inv_start);
        bit          exp_hit;
        bit          quiet;
        bit          inv_seen;
        logic        req0;
        logic [24:0] exp_addr;
        exp_hit  = m_valid && (m_tag == addr[19:3]) && !inv_start;
        exp_addr = ROM_BASE + {5'd0, addr[19:3], 3'b000};
        req0     = sdr_req;
        rom_addr = addr; cpu_rd = 1'b1; cpu_rom_memrq = 1'b1; invalidate = inv_start;
        step();
        cpu_rd = 1'b0; cpu_rom_memrq = 1'b0; invalidate = 1'b0;
        if (inv_start) m_valid = 1'b0;
        if (exp_hit) begin
            chk("hit_ready", {63'd0, cpu_ready}, 64'd1);
            chk("hit_dout", {48'd0, cpu_dout}, {48'd0, word_of(m_data, addr)});
            chk("hit_no_req", {63'd0, sdr_req}, {63'd0, req0});
        end else begin
            chk("miss_req_toggle", {63'd0, sdr_req}, {63'd0, ~req0});
            chk("miss_sdr_addr", {39'd0, sdr_addr}, {39'd0, exp_addr});
            chk("miss_no_early_ready", {63'd0, cpu_ready}, 64'd0);
            quiet = 1'b1; inv_seen = 1'b0;
            for (int c = 0; c < lat; c++) begin
                invalidate = (c == inv_cycle);
                if (c == inv_cycle) inv_seen = 1'b1;
                cpu_rd = 1'(($urandom & 1));
                cpu_rom_memrq = 1'b1;
                rom_addr = 20'($urandom);
                sdr_data = {$urandom, $urandom};
                step();
                if (cpu_ready !== 1'b0 || sdr_addr !== exp_addr) quiet = 1'b0;
            end
            cpu_rd = 1'b0; cpu_rom_memrq = 1'b0;
            invalidate = (inv_cycle == lat);
            if (inv_cycle == lat) inv_seen = 1'b1;
            sdr_data = line;
            sdr_ack  = sdr_req;
            step();
            invalidate = 1'b0;
            chk("wait_quiet", {63'd0, quiet}, 64'd1);
            chk("fill_not_yet_ready", {63'd0, cpu_ready}, 64'd0);
            sdr_data = {$urandom, $urandom};
            step();
            chk("miss_ready", {63'd0, cpu_ready}, 64'd1);
            chk("miss_dout", {48'd0, cpu_dout}, {48'd0, word_of(line, addr)});
            m_tag = addr[19:3]; m_data = line; m_valid = !inv_seen;
        end
        step();
        chk("ready_one_pulse", {63'd0, cpu_ready}, 64'd0);
    endtask

    initial begin
        logic        req0;
        bit          quiet;
        logic [16:0] tags [4];
        logic [19:0] a;
        int          lat;
        int          inv_c;

        reset_n = 1'b0; cpu_rd = 1'b0; cpu_rom_memrq = 1'b0; invalidate = 1'b0;
        rom_addr = '0; sdr_ack = 1'b1; sdr_data = '0;
        m_valid = 1'b0; m_tag = '0; m_data = '0;
        step(); step(); step();
        chk("rst_ready", {63'd0, cpu_ready}, 64'd0);
        chk("rst_dout", {48'd0, cpu_dout}, 64'd0);
        chk("rst_sdr_addr", {39'd0, sdr_addr}, 64'd0);
        chk("rst_req_resync", {63'd0, sdr_req}, 64'd1);
        reset_n = 1'b1;
        step();

        // Cold miss, then hit in the same line
        do_read(20'h00006, 64'h4444_3333_2222_1111, 5, -1, 1'b0);
        chk("cold_dout", {48'd0, cpu_dout}, 64'h4444);
        do_read(20'h00002, 64'h0, 0, -1, 1'b0);
        chk("hit_dout_2222", {48'd0, cpu_dout}, 64'h2222);

        // Invalidate during WAIT: data delivered, line not kept
        do_read(20'h12340, 64'h0123_4567_89AB_BEEF, 6, 2, 1'b0);
        chk("inv_wait_dout", {48'd0, cpu_dout}, 64'hBEEF);
        do_read(20'h12340, 64'h5555_6666_7777_8888, 3, -1, 1'b0);

        // Top of ROM: reset-vector line, then word 3 hit without carry
        do_read(20'h7fff8, 64'hAAAA_BBBB_CCCC_DDDD, 4, -1, 1'b0);
        do_read(20'h7fffe, 64'h0, 0, -1, 1'b0);
        chk("top_word3", {48'd0, cpu_dout}, 64'hAAAA);

        // Non-ROM bus cycle is ignored
        req0 = sdr_req; quiet = 1'b1;
        rom_addr = 20'h00100; cpu_rd = 1'b1; cpu_rom_memrq = 1'b0;
        step();
        cpu_rd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cpu_ready !== 1'b0) quiet = 1'b0;
            step();
        end
        chk("nonrom_no_ready", {63'd0, quiet}, 64'd1);
        chk("nonrom_no_req", {63'd0, sdr_req}, {63'd0, req0});

        // Invalidate on the ack cycle, then invalidate coincident with a start
        do_read(20'h00a14, 64'h1234_5678_9abc_def0, 3, 3, 1'b0);
        do_read(20'h00a12, 64'h0fed_cba9_8765_4321, 2, -1, 1'b0);
        do_read(20'h00a10, 64'h1111_2222_3333_4444, 2, -1, 1'b1);

        // Reset mid-WAIT with an ack toggle during reset
        rom_addr = 20'h0abc0; cpu_rd = 1'b1; cpu_rom_memrq = 1'b1;
        step();
        cpu_rd = 1'b0; cpu_rom_memrq = 1'b0;
        step();
        reset_n = 1'b0;
        step();
        sdr_ack = ~sdr_ack;
        step();
        reset_n = 1'b1;
        m_valid = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (cpu_ready !== 1'b0) quiet = 1'b0;
            step();
        end
        chk("rstwait_req_eq_ack", {63'd0, sdr_req}, {63'd0, sdr_ack});
        chk("rstwait_no_ready", {63'd0, quiet}, 64'd1);
        chk("rstwait_dout", {48'd0, cpu_dout}, 64'd0);
        do_read(20'h0abc2, 64'hCAFE_F00D_DEAD_BEEF, 4, -1, 1'b0);
        chk("post_rst_dout", {48'd0, cpu_dout}, 64'hDEAD);

        // Randomized reads over a few lines to mix hits, misses and invalidates
        for (int i = 0; i < 4; i++) tags[i] = 17'($urandom);
        for (int it = 0; it < 40; it++) begin
            a     = {tags[$urandom_range(0, 3)], 2'($urandom), 1'b0};
            lat   = $urandom_range(1, 6);
            inv_c = ($urandom_range(0, 7) == 0) ? $urandom_range(0, lat) : -1;
            do_read(a, {$urandom, $urandom}, lat, inv_c, ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 9) == 0) begin
                invalidate = 1'b1;
                step();
                invalidate = 1'b0;
                m_valid = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
